alu: RTL and testbench

ALU -- requirements
Module: Alu

---
 rtl/alu.sv | 129 ++++++++++++
 tb/tb_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle registered ALU: N-bit arithmetic, logic, shift and multiply ops with
// ARM-style NZCV flags. A synchronous active-low reset clears the result and all flags.
module alu #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   AluControl,
   output logic [N-1:0] AluResult,
   output logic         z,
   output logic         n,
   output logic         c,
   output logic         v
);

   localparam logic [3:0] OpAdd = 4'b0000;
   localparam logic [3:0] OpSub = 4'b0001;
   localparam logic [3:0] OpAnd = 4'b0010;
   localparam logic [3:0] OpOrr = 4'b0011;
   localparam logic [3:0] OpEor = 4'b0100;
   localparam logic [3:0] OpRsb = 4'b0101;
   localparam logic [3:0] OpBic = 4'b0110;
   localparam logic [3:0] OpMov = 4'b0111;
   localparam logic [3:0] OpMvn = 4'b1000;
   localparam logic [3:0] OpLsl = 4'b1001;
   localparam logic [3:0] OpLsr = 4'b1010;
   localparam logic [3:0] OpAsr = 4'b1011;
   localparam logic [3:0] OpRor = 4'b1100;
   localparam logic [3:0] OpMul = 4'b1101;

   localparam logic [N-1:0] NVal = N'(N);

   logic [N:0]        sumAB;
   logic [N:0]        diffAB;
   logic [N:0]        diffBA;
   logic [N:0]        lslWide;
   logic [N:0]        lsrWide;
   logic signed [N:0] asrWide;
   logic [N-1:0]      rotAmt;
   logic [N-1:0]      rorRes;
   logic [N-1:0]      mulRes;

   logic [N-1:0] resultD;
   logic         zD;
   logic         nD;
   logic         cD;
   logic         vD;

   // Shifters carry one extra bit so the last bit shifted out lands in a fixed position.
   always_comb begin
      sumAB   = {1'b0, a} + {1'b0, b};
      diffAB  = {1'b0, a} - {1'b0, b};
      diffBA  = {1'b0, b} - {1'b0, a};
      lslWide = {1'b0, a} << b;
      lsrWide = {a, 1'b0} >> b;
      asrWide = $signed({a, 1'b0}) >>> b;
      rotAmt  = N'(b % N);
      rorRes  = (a >> rotAmt) | (a << (NVal - rotAmt));
      mulRes  = a * b;
   end

   always_comb begin
      resultD = '0;
      cD      = 1'b0;
      vD      = 1'b0;
      case (AluControl)
         OpAdd: begin
            resultD = sumAB[N-1:0];
            cD      = sumAB[N];
            vD      = (a[N-1] == b[N-1]) && (sumAB[N-1] != a[N-1]);
         end
         OpSub: begin
            resultD = diffAB[N-1:0];
            cD      = ~diffAB[N];
            vD      = (a[N-1] != b[N-1]) && (diffAB[N-1] != a[N-1]);
         end
         OpRsb: begin
            resultD = diffBA[N-1:0];
            cD      = ~diffBA[N];
            vD      = (a[N-1] != b[N-1]) && (diffBA[N-1] != b[N-1]);
         end
         OpAnd: resultD = a & b;
         OpOrr: resultD = a | b;
         OpEor: resultD = a ^ b;
         OpBic: resultD = a & ~b;
         OpMov: resultD = b;
         OpMvn: resultD = ~b;
         OpLsl: begin
            resultD = lslWide[N-1:0];
            cD      = lslWide[N];
         end
         OpLsr: begin
            resultD = lsrWide[N:1];
            cD      = lsrWide[0];
         end
         OpAsr: begin
            resultD = asrWide[N:1];
            cD      = asrWide[0];
         end
         OpRor: begin
            resultD = rorRes;
            cD      = (rotAmt != '0) && rorRes[N-1];
         end
         OpMul: resultD = mulRes;
         default: ;
      endcase
      zD = (resultD == '0);
      nD = resultD[N-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         AluResult <= '0;
         z         <= 1'b0;
         n         <= 1'b0;
         c         <= 1'b0;
         v         <= 1'b0;
      end else begin
         AluResult <= resultD;
         z         <= zD;
         n         <= nD;
         c         <= cD;
         v         <= vD;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Randomised bench for alu: stimulus pushes expected results into a queue, a monitor
// pops one entry per clock edge and compares it against the registered outputs.
module tb_alu;

   localparam int unsigned N = 3;
   localparam int M = 1 << N;
   localparam int Half = M / 2;

   typedef struct {
      int res;
      bit z;
      bit n;
      bit c;
      bit v;
      bit cCare;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   AluControl;
   logic [N-1:0] AluResult;
   logic         z;
   logic         n;
   logic         c;
   logic         v;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   alu #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .AluControl (AluControl),
      .AluResult  (AluResult),
      .z          (z),
      .n          (n),
      .c          (c),
      .v          (v)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int toSigned(int x);
      return (x >= Half) ? x - M : x;
   endfunction

   // Reference: plain integer arithmetic on the operation's meaning.
   function automatic exp_t model(int ai, int bi, int op, bit rst);
      exp_t e;
      int sa, sb, s, r;
      e.res = 0; e.c = 0; e.v = 0; e.cCare = 1;
      if (rst) begin
         e.z = 0; e.n = 0;
         return e;
      end
      sa = toSigned(ai);
      sb = toSigned(bi);
      case (op)
         0: begin
            s = ai + bi; e.res = s % M; e.c = (s >= M);
            e.v = (sa + sb < -Half) || (sa + sb > Half - 1);
         end
         1: begin
            e.res = (ai - bi + M) % M; e.c = (ai >= bi);
            e.v = (sa - sb < -Half) || (sa - sb > Half - 1);
         end
         5: begin
            e.res = (bi - ai + M) % M; e.c = (bi >= ai);
            e.v = (sb - sa < -Half) || (sb - sa > Half - 1);
         end
         2: e.res = ai & bi;
         3: e.res = ai | bi;
         4: e.res = ai ^ bi;
         6: e.res = ai & ~bi & (M - 1);
         7: e.res = bi;
         8: e.res = ~bi & (M - 1);
         9: begin
            if (bi == 0) e.res = ai;
            else if (bi >= N) e.cCare = 0;
            else begin
               e.res = (ai * (1 << bi)) % M; e.c = ((ai >> (N - bi)) & 1) != 0;
            end
         end
         10: begin
            if (bi == 0) e.res = ai;
            else if (bi >= N) e.cCare = 0;
            else begin
               e.res = ai / (1 << bi); e.c = ((ai >> (bi - 1)) & 1) != 0;
            end
         end
         11: begin
            if (bi >= N) begin
               e.res = (sa < 0) ? M - 1 : 0; e.c = (sa < 0);
            end else begin
               e.res = (sa >>> bi) & (M - 1);
               e.c = (bi != 0) && (((ai >> (bi - 1)) & 1) != 0);
            end
         end
         12: begin
            r = bi % N;
            e.res = ((ai * M + ai) >> r) & (M - 1);
            e.c = (r != 0) && (e.res >= Half);
         end
         13: e.res = (ai * bi) % M;
         default: e.res = 0;
      endcase
      e.z = (e.res == 0);
      e.n = (e.res >= Half);
      return e;
   endfunction

   task automatic issue(bit rst, int ai, int bi, int op, exp_t e);
      @(negedge clk);
      rst_n = ~rst;
      a = N'(ai);
      b = N'(bi);
      AluControl = 4'(op);
      expQ.push_back(e);
   endtask

   task automatic issueConst(bit rst, int ai, int bi, int op,
                             int res, bit ez, bit en, bit ec, bit ev);
      exp_t e;
      e.res = res; e.z = ez; e.n = en; e.c = ec; e.v = ev; e.cCare = 1;
      issue(rst, ai, bi, op, e);
   endtask

   // Monitor: one result per edge whenever something was issued.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checks++;
            if (int'(AluResult) != e.res || z !== e.z || n !== e.n || v !== e.v ||
                (e.cCare && c !== e.c)) begin
               errors++;
               $display("FAIL result/flags: got res=%0d z=%0b n=%0b c=%0b v=%0b, expected res=%0d z=%0b n=%0b c=%0b(care %0b) v=%0b",
                        AluResult, z, n, c, v, e.res, e.z, e.n, e.c, e.cCare, e.v);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int ai, bi, op;
      bit rst;
      rst_n = 1'b0; a = '0; b = '0; AluControl = '0;
      // Reset overrides a live ADD, then the first released edge performs it.
      issueConst(1, 7, 1, 0, 0, 0, 0, 0, 0);
      issueConst(1, 7, 1, 0, 0, 0, 0, 0, 0);
      issueConst(0, 7, 1, 0, 0, 1, 0, 1, 0);
      issueConst(0, 1, 2, 1, 7, 0, 1, 0, 0);
      issueConst(0, 4, 4, 0, 0, 1, 0, 1, 1);
      issueConst(0, 2, 6, 0, 0, 1, 0, 1, 0);
      issueConst(0, 3, 1, 0, 4, 0, 1, 0, 1);
      issueConst(0, 4, 1, 11, 6, 0, 1, 0, 0);
      issueConst(0, 5, 3, 14, 0, 1, 0, 0, 0);
      issueConst(0, 6, 2, 15, 0, 1, 0, 0, 0);
      issueConst(0, 5, 7, 11, 7, 0, 1, 1, 0);
      issueConst(0, 3, 2, 12, 6, 0, 1, 1, 0);
      issueConst(1, 3, 3, 2, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 24) == 0);
         ai = $urandom_range(0, M - 1);
         bi = $urandom_range(0, M - 1);
         op = $urandom_range(0, 15);
         issue(rst, ai, bi, op, model(ai, bi, op, rst));
      end
      repeat (3) @(posedge clk);
      #2;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected results never observed, required 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
